// File: rtl/aes_cbc_ctrl.sv
// aes_cbc_ctrl: CBC chaining controller between spi_slave and an AES-128 core,
// with core start/done handshake, response timeout and overrun flagging.
module aes_cbc_ctrl #(
  parameter int BLOCK_W      = 128,
  parameter int CORE_TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_encryption,
  input  logic               new_message,
  input  logic [BLOCK_W-1:0] plaintext,
  input  logic [BLOCK_W-1:0] key,
  input  logic [BLOCK_W-1:0] iv,
  output logic [BLOCK_W-1:0] ciphertext,
  output logic               encryption_done,
  output logic               busy,
  output logic [1:0]         error,
  output logic               core_start,
  output logic [BLOCK_W-1:0] core_key,
  output logic [BLOCK_W-1:0] core_block,
  input  logic               core_done,
  input  logic [BLOCK_W-1:0] core_result
);
  localparam int CW = $clog2(CORE_TIMEOUT);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [BLOCK_W-1:0] chain_q;
  logic               chain_valid_q;
  logic [BLOCK_W-1:0] chain_d;
  logic               timeout;
  assign chain_d = (new_message | ~chain_valid_q) ? iv : chain_q;
  assign timeout = cnt_q == CW'(CORE_TIMEOUT - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      chain_q         <= '0;
      chain_valid_q   <= 1'b0;
      ciphertext      <= '0;
      encryption_done <= 1'b0;
      busy            <= 1'b0;
      error           <= 2'b00;
      core_start      <= 1'b0;
      core_key        <= '0;
      core_block      <= '0;
    end else begin
      core_start      <= 1'b0;
      encryption_done <= 1'b0;
      case (state_q)
        IDLE: if (start_encryption) begin
          core_key   <= key;
          core_block <= plaintext ^ chain_d;
          error      <= 2'b00;
          core_start <= 1'b1;
          busy       <= 1'b1;
          state_q    <= ISSUE;
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q + CW'(1);
          if (core_done) begin
            ciphertext      <= core_result;
            chain_q         <= core_result;
            chain_valid_q   <= 1'b1;
            encryption_done <= 1'b1;
            state_q         <= DONE;
          end else if (timeout) begin
            error[0]        <= 1'b1;
            chain_valid_q   <= 1'b0;
            encryption_done <= 1'b1;
            state_q         <= DONE;
          end
        end
        DONE: begin
          busy    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
      if (start_encryption && state_q != IDLE) error[1] <= 1'b1;
    end
  end
endmodule

// File: tb/tb_aes_cbc_ctrl.sv
// tb_aes_cbc_ctrl: randomized CBC transactions against a chaining reference model
// and a fixed-latency XOR stand-in for the AES core.
module tb_aes_cbc_ctrl;
  logic         clk = 1'b0;
  logic         rst;
  logic         start_encryption, new_message;
  logic [127:0] plaintext, key, iv, ciphertext, core_key, core_block;
  logic         encryption_done, busy, core_start;
  logic [1:0]   error;
  logic         core_done = 1'b0;
  logic [127:0] core_result = '0;
  logic         core_en = 1'b1;
  int           dly = 0;
  int           checks = 0, failures = 0;
  logic [127:0] chain_ref = '0, ct_ref = '0;
  bit           cv_ref = 1'b0;

  localparam logic [127:0] K1 = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] IV1 = 128'hAABBCCDDEEFF00112233445566778899;
  localparam logic [127:0] PT1 = 128'h112233445566778899AABBCCDDEEFF00;
  localparam logic [127:0] CT1 = 128'hBB88DDAAFFCC11EE3300552277449966;

  aes_cbc_ctrl #(.BLOCK_W(128), .CORE_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start_encryption(start_encryption), .new_message(new_message),
    .plaintext(plaintext), .key(key), .iv(iv), .ciphertext(ciphertext),
    .encryption_done(encryption_done), .busy(busy), .error(error), .core_start(core_start),
    .core_key(core_key), .core_block(core_block), .core_done(core_done), .core_result(core_result)
  );

  always #5 clk = ~clk;

  // Stand-in core: result = block ^ key, core_done 10 cycles after core_start.
  always @(posedge clk) begin
    core_done <= 1'b0;
    if (core_start && core_en) begin
      dly         <= 9;
      core_result <= core_block ^ core_key;
    end else if (dly != 0) begin
      dly <= dly - 1;
      if (dly == 1) core_done <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic op(input logic nm, input logic [127:0] pt, input logic [127:0] k,
                    input logic [127:0] v, input bit silent, input bit ovr, input bit chg);
    logic [127:0] eb, ect;
    int cyc;
    core_en = !silent;
    eb  = pt ^ ((nm || !cv_ref) ? v : chain_ref);
    ect = eb ^ k;
    new_message = nm; plaintext = pt; key = k; iv = v; start_encryption = 1'b1;
    @(negedge clk);
    start_encryption = 1'b0;
    cyc = 1;
    chk("core_start", core_start, 1'b1);
    chk("core_block", core_block, eb);
    chk("core_key", core_key, k);
    chk("busy", busy, 1'b1);
    if (chg) begin
      plaintext = rnd128(); key = rnd128(); iv = rnd128(); new_message = ~nm;
    end
    while (!encryption_done && cyc < 40) begin
      start_encryption = ovr && cyc == 5;
      @(negedge clk);
      cyc++;
      chk("core_start_once", core_start, 1'b0);
    end
    start_encryption = 1'b0;
    chk("done_cycle", cyc, silent ? 18 : 12);
    chk("error", error, {ovr, silent});
    chk("ciphertext", ciphertext, silent ? ct_ref : ect);
    chk("core_block_held", core_block, eb);
    chk("core_key_held", core_key, k);
    if (!silent) begin
      ct_ref = ect; chain_ref = ect; cv_ref = 1'b1;
    end else cv_ref = 1'b0;
    start_encryption = ovr;
    @(negedge clk);
    start_encryption = 1'b0;
    chk("done_pulse", encryption_done, 1'b0);
    chk("busy_idle", busy, 1'b0);
    chk("error_after", error, {ovr, silent});
    core_en = 1'b1;
  endtask

  initial begin
    rst = 1'b1; start_encryption = 1'b0; new_message = 1'b0;
    plaintext = '0; key = '0; iv = '0;
    repeat (2) @(negedge clk);
    chk("rst_ct", ciphertext, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", error, 2'b00);
    chk("rst_done", encryption_done, 1'b0);
    chk("rst_cs", core_start, 1'b0);
    chk("rst_ck", core_key, '0);
    chk("rst_cb", core_block, '0);
    rst = 1'b0;
    @(negedge clk);
    op(1'b1, PT1, K1, IV1, 0, 0, 0);
    chk("t1_ct", ciphertext, CT1);
    op(1'b0, PT1, K1, IV1, 0, 0, 0);
    op(1'b1, rnd128(), rnd128(), rnd128(), 1, 0, 0);
    op(1'b0, rnd128(), rnd128(), rnd128(), 0, 0, 0);
    op(1'b1, PT1, K1, IV1, 0, 1, 0);
    chk("t4_ct", ciphertext, CT1);
    new_message = 1'b1; plaintext = PT1; key = K1; iv = IV1; start_encryption = 1'b1;
    @(negedge clk);
    start_encryption = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_ct", ciphertext, '0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_err", error, 2'b00);
    chk("arst_done", encryption_done, 1'b0);
    chk("arst_cs", core_start, 1'b0);
    chk("arst_ck", core_key, '0);
    chk("arst_cb", core_block, '0);
    @(negedge clk);
    rst = 1'b0;
    cv_ref = 1'b0; chain_ref = '0; ct_ref = '0;
    repeat (15) begin
      @(negedge clk);
      chk("no_done_after_rst", encryption_done, 1'b0);
    end
    op(1'b0, PT1, K1, IV1, 0, 0, 0);
    chk("t5_ct", ciphertext, CT1);
    op(1'b0, rnd128(), rnd128(), rnd128(), 0, 0, 1);
    for (int i = 0; i < 10; i++)
      op(1'($urandom_range(0, 1)), rnd128(), rnd128(), rnd128(),
         $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
